// File: rtl/timer_keypad_ctrl.sv
// rtl/timer_keypad_ctrl.sv - keypad scan/debounce front-end and control FSM for the countdown timer (optional beep: TIMER_KEYPAD_BEEP_EN)
module timer_keypad_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic [12:0] keys,
  input  logic        zero,
  output logic [3:0]  data,
  output logic        loadn,
  output logic        en,
  output logic        tclrn,
  output logic [1:0]  digit_cnt,
  output logic        busy
`ifdef TIMER_KEYPAD_BEEP_EN
  ,
  output logic        beep
`endif
);

  localparam logic [7:0] DEB  = 8'(DEBOUNCE_CYCLES);
  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);

  localparam logic [3:0] K_START = 4'd10;
  localparam logic [3:0] K_STOP  = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  logic [12:0] key_s1;
  logic [12:0] key_s2;
  logic [12:0] cand;
  logic [7:0]  deb_cnt;
  logic [12:0] stable_q;
  logic        ev_q;
  logic [3:0]  ev_idx_q;

  logic        valid;
  logic        cand_onehot;
  logic [3:0]  cand_idx;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  data_d;
  logic        loadn_d;
  logic        en_d;
  logic        tclrn_d;
  logic [1:0]  digit_cnt_d;
  logic        busy_d;

  logic        is_digit;
  logic        is_start;
  logic        is_stop;
  logic        is_clear;

  // Two-flop synchronizer on the raw key vector
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= keys;
      key_s2 <= key_s1;
    end
  end

  // Debounce: deb_cnt counts consecutive cycles the candidate vector has been unchanged
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cand    <= '0;
      deb_cnt <= '0;
    end else if (key_s2 != cand) begin
      cand    <= key_s2;
      deb_cnt <= 8'd1;
    end else if (deb_cnt != DEB) begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign valid       = (deb_cnt == DEB);
  assign cand_onehot = (cand != '0) && ((cand & (cand - 13'd1)) == '0);

  // Index of the set bit in the candidate vector (meaningful only when one-hot)
  always_comb begin
    cand_idx = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (cand[i]) cand_idx = 4'(i);
    end
  end

  // Press event: accepted vector moves from all-zero to exactly one bit set
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      stable_q <= '0;
      ev_q     <= 1'b0;
      ev_idx_q <= '0;
    end else begin
      ev_q     <= valid && cand_onehot && (stable_q == '0);
      ev_idx_q <= cand_idx;
      if (valid) stable_q <= cand;
    end
  end

  assign is_digit = ev_q && (ev_idx_q <= 4'd9);
  assign is_start = ev_q && (ev_idx_q == K_START);
  assign is_stop  = ev_q && (ev_idx_q == K_STOP);
  assign is_clear = ev_q && (ev_idx_q == K_CLEAR);

  // State and registered outputs
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      data      <= '0;
      loadn     <= 1'b1;
      en        <= 1'b0;
      tclrn     <= 1'b1;
      digit_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data      <= data_d;
      loadn     <= loadn_d;
      en        <= en_d;
      tclrn     <= tclrn_d;
      digit_cnt <= digit_cnt_d;
      busy      <= busy_d;
    end
  end

  // Next state and next output values; clear overrides everything, zero beats stop in RUN
  always_comb begin
    state_d     = state_q;
    data_d      = data;
    loadn_d     = 1'b1;
    en_d        = en;
    tclrn_d     = 1'b1;
    digit_cnt_d = digit_cnt;
    if (is_clear) begin
      tclrn_d     = 1'b0;
      en_d        = 1'b0;
      digit_cnt_d = '0;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            data_d      = ev_idx_q;
            loadn_d     = 1'b0;
            digit_cnt_d = 2'd1;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: begin
          if (is_digit) begin
            if (digit_cnt < MAXD) begin
              data_d      = ev_idx_q;
              loadn_d     = 1'b0;
              digit_cnt_d = digit_cnt + 2'd1;
            end
          end else if (is_start && !zero) begin
            en_d    = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (zero) begin
            en_d        = 1'b0;
            digit_cnt_d = '0;
            state_d     = S_DONE;
          end else if (is_stop) begin
            en_d    = 1'b0;
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (is_start) begin
            en_d    = 1'b1;
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          // A digit here starts a fresh entry directly
          if (is_digit) begin
            data_d      = ev_idx_q;
            loadn_d     = 1'b0;
            digit_cnt_d = 2'd1;
            state_d     = S_LOAD;
          end else if (is_start || is_stop) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          en_d        = 1'b0;
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

`ifdef TIMER_KEYPAD_BEEP_EN
  logic [15:0] beep_cnt;

  // Beep for 2^16 cycles on entry to DONE; any press (including clear) silences it
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      beep     <= 1'b1;
      beep_cnt <= 16'hFFFF;
    end else if (beep) begin
      if (ev_q || (beep_cnt == 16'd0)) begin
        beep <= 1'b0;
      end else begin
        beep_cnt <= beep_cnt - 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_timer_keypad_ctrl.sv
// tb/tb_timer_keypad_ctrl.sv - self-checking bench for timer_keypad_ctrl
module tb_timer_keypad_ctrl;

  localparam int DEB  = 4;
  localparam int MAXD = 3;
  localparam int HL   = DEB + 3;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic [12:0] keys  = '0;
  logic        zero  = 1'b0;
  logic [3:0]  data;
  logic        loadn;
  logic        en;
  logic        tclrn;
  logic [1:0]  digit_cnt;
  logic        busy;
`ifdef TIMER_KEYPAD_BEEP_EN
  logic        beep;
`endif

  always #5 clock = ~clock;

  timer_keypad_ctrl #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
    .clock(clock),
    .clrn(clrn),
    .keys(keys),
    .zero(zero),
    .data(data),
    .loadn(loadn),
    .en(en),
    .tclrn(tclrn),
    .digit_cnt(digit_cnt),
`ifdef TIMER_KEYPAD_BEEP_EN
    .busy(busy),
    .beep(beep)
`else
    .busy(busy)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: raw key history, acceptance window, controller rules
  logic [12:0] hist [HL];
  logic [12:0] m_stable;
  logic [12:0] m_w;
  bit          m_ok;
  bit          m_ev;
  int          m_key;
  int          m_mode;
  int          m_prev_mode;
  int          m_data;
  int          m_cnt;
  bit          m_loadn;
  bit          m_en;
  bit          m_tclrn;
  bit          m_busy;
  bit          m_beep;

  // Outputs after edge n reflect a press whose raw vector was seen for DEB samples, 3 edges earlier
  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_stable = '0;
      m_mode = M_IDLE;
      m_data = 0;
      m_cnt = 0;
      m_loadn = 1;
      m_en = 0;
      m_tclrn = 1;
      m_busy = 0;
      m_beep = 0;
    end else begin
      m_w = hist[3];
      m_ok = 1;
      for (int k = 3; k < HL; k++) if (hist[k] != m_w) m_ok = 0;
      m_ev = 0;
      m_key = -1;
      if (m_ok) begin
        if ($countones(m_w) == 1 && m_stable == 0) begin
          m_ev = 1;
          for (int b = 0; b < 13; b++) if (m_w[b]) m_key = b;
        end
        m_stable = m_w;
      end
      m_prev_mode = m_mode;
      m_loadn = 1;
      m_tclrn = 1;
      if (m_ev && m_key == 12) begin
        m_tclrn = 0; m_en = 0; m_cnt = 0; m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE:
            if (m_ev && m_key < 10) begin
              m_data = m_key; m_loadn = 0; m_cnt = 1; m_mode = M_LOAD;
            end
          M_LOAD:
            if (m_ev && m_key < 10) begin
              if (m_cnt < MAXD) begin
                m_data = m_key; m_loadn = 0; m_cnt = m_cnt + 1;
              end
            end else if (m_ev && m_key == 10 && !zero) begin
              m_en = 1; m_mode = M_RUN;
            end
          M_RUN:
            if (zero) begin
              m_en = 0; m_cnt = 0; m_mode = M_DONE;
            end else if (m_ev && m_key == 11) begin
              m_en = 0; m_mode = M_PAUSE;
            end
          M_PAUSE:
            if (m_ev && m_key == 10) begin
              m_en = 1; m_mode = M_RUN;
            end
          default:
            if (m_ev && m_key < 10) begin
              m_data = m_key; m_loadn = 0; m_cnt = 1; m_mode = M_LOAD;
            end else if (m_ev && (m_key == 10 || m_key == 11)) begin
              m_mode = M_IDLE;
            end
        endcase
      end
      m_busy = (m_mode == M_RUN) || (m_mode == M_PAUSE);
      if (m_mode == M_DONE && m_prev_mode != M_DONE) m_beep = 1;
      else if (m_ev) m_beep = 0;
      for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = keys;
    end
  end

  // Per-cycle comparison against the model plus output invariants
  always @(negedge clock) begin
    if (clrn) begin
      chk("data", int'(data), m_data);
      chk("loadn", int'(loadn), int'(m_loadn));
      chk("en", int'(en), int'(m_en));
      chk("tclrn", int'(tclrn), int'(m_tclrn));
      chk("digit_cnt", int'(digit_cnt), m_cnt);
      chk("busy", int'(busy), int'(m_busy));
`ifdef TIMER_KEYPAD_BEEP_EN
      chk("beep", int'(beep), int'(m_beep));
`endif
      chk("loadn_low_with_en", int'(!loadn && en), 0);
      chk("loadn_low_with_tclrn", int'(!loadn && !tclrn), 0);
    end
  end

  int strobe_n = 0;
  int clr_n    = 0;
  int strobe_data [$];

  // Record every load strobe and clear pulse seen on the outputs
  always @(negedge clock) begin
    if (clrn) begin
      if (!loadn) begin
        strobe_n++;
        strobe_data.push_back(int'(data));
      end
      if (!tclrn) clr_n++;
    end
  end

  task automatic press(input int k);
    keys = 13'd1 << k;
    repeat (10) @(negedge clock);
    keys = '0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_data", int'(data), 0);
    chk("rst_loadn", int'(loadn), 1);
    chk("rst_en", int'(en), 0);
    chk("rst_tclrn", int'(tclrn), 1);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    clrn = 1'b1;
    repeat (3) @(negedge clock);

    // First digit: strobe must appear exactly 7 cycles after the edge that samples the key
    keys = 13'd1 << 2;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      chk($sformatf("latency_%0d", i), int'(loadn), (i == 8) ? 0 : 1);
    end
    keys = '0;
    repeat (12) @(negedge clock);
    press(1);
    press(5);
    press(9);
    chk("strobe_count_3", strobe_n, 3);
    chk("strobe0_data", strobe_data[0], 2);
    chk("strobe1_data", strobe_data[1], 1);
    chk("strobe2_data", strobe_data[2], 5);
    chk("digit_cnt_sat", int'(digit_cnt), 3);

    // Short glitch, then two keys at once: neither is a press
    keys = 13'd1 << 4;
    repeat (3) @(negedge clock);
    keys = '0;
    repeat (12) @(negedge clock);
    keys = (13'd1 << 3) | (13'd1 << 7);
    repeat (10) @(negedge clock);
    keys = '0;
    repeat (12) @(negedge clock);
    chk("no_glitch_strobe", strobe_n, 3);

    press(12);
    chk("clear_pulses_1", clr_n, 1);
    chk("clear_digit_cnt", int'(digit_cnt), 0);

    press(1);
    press(0);
    press(0);
    chk("strobe_count_6", strobe_n, 6);
    press(10);
    chk("run_en", int'(en), 1);
    chk("run_busy", int'(busy), 1);
    press(11);
    chk("pause_en", int'(en), 0);
    chk("pause_busy", int'(busy), 1);
    press(10);
    chk("resume_en", int'(en), 1);

    // zero arrives on the same edge as the stop event: DONE wins over PAUSE
    keys = 13'd1 << 11;
    repeat (7) @(negedge clock);
    zero = 1'b1;
    repeat (3) @(negedge clock);
    keys = '0;
    repeat (12) @(negedge clock);
    chk("done_en", int'(en), 0);
    chk("done_busy", int'(busy), 0);
    chk("done_digit_cnt", int'(digit_cnt), 0);
`ifdef TIMER_KEYPAD_BEEP_EN
    chk("done_beep", int'(beep), 1);
`endif

    press(7);
    chk("done_digit_data", int'(data), 7);
    chk("done_digit_cnt1", int'(digit_cnt), 1);
    chk("strobe_count_7", strobe_n, 7);
`ifdef TIMER_KEYPAD_BEEP_EN
    chk("beep_off_press", int'(beep), 0);
`endif
    press(10);
    chk("start_zero_held", int'(en), 0);
    zero = 1'b0;
    press(10);
    chk("start_again_en", int'(en), 1);
    press(12);
    chk("clear_pulses_2", clr_n, 2);
    chk("clear_run_en", int'(en), 0);
    chk("clear_run_busy", int'(busy), 0);
    chk("clear_run_cnt", int'(digit_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timer_keypad_ctrl.md
Name: timer_keypad_ctrl

Overview:
- Front-end controller for the minutes/seconds countdown timer.
- Scans a one-hot keypad of digits plus start, stop and clear keys, then debounces and edge-detects each press.
- Drives the timer's serial digit-load interface (data, loadn), its count enable (en) and its clear (clrn), and reacts to the timer's zero flag.
- Sits between the front-panel keys and the timer, on the same clock.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized key vector must be stable before it is accepted (range 1 to 255)
MAX_DIGITS, 3, maximum digits shifted into the timer per entry; further digits are ignored

Ports:
clock  input  1  system clock, rising edge
clrn  input  1  asynchronous active-low reset
keys  input  13  raw keys, active-high; bits 0-9 = digits 0-9, bit 10 = start, bit 11 = stop, bit 12 = clear
zero  input  1  timer's zero flag (timer at 0:00)
data  output  4  digit presented to the timer
loadn  output  1  active-low, one-cycle digit-load strobe to the timer
en  output  1  timer count enable
tclrn  output  1  active-low, one-cycle clear to the timer
digit_cnt  output  2  digits loaded in the current entry
busy  output  1  high in RUN or PAUSE

Behaviour:
- Reset (clrn low, asynchronous) forces:
  - state IDLE, data=0, loadn=1, en=0, tclrn=1, digit_cnt=0, busy=0;
  - synchronizers and debounce counter cleared.
  - Reset mid-entry or mid-run simply abandons the operation.
- Input path:
  - 2-flop synchronizer on keys.
  - Debounce counter restarts whenever the synchronized vector changes; the vector is "stable" after DEBOUNCE_CYCLES unchanged cycles.
- Press event:
  - Fires on the transition stable all-zero -> stable exactly-one-bit-set, one cycle only.
  - A stable value with more than one bit set produces no event; a new event then needs a return to stable zero.
  - A held key produces exactly one event.
- All outputs are registered.
- Latency from a raw key edge to the strobe is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Digit load:
  - data is set to the digit value and loadn is driven low for exactly one cycle.
  - data holds its value after the strobe.
  - digit_cnt increments, saturating at MAX_DIGITS.
- Clear: tclrn low for exactly one cycle, en=0, digit_cnt=0, go to IDLE. Valid from any state.
- States:
  - IDLE:
    - digit -> load, digit_cnt=1, go to LOAD;
    - start -> ignored;
    - stop -> ignored;
    - clear -> clear pulse.
  - LOAD:
    - digit -> load if digit_cnt<MAX_DIGITS, otherwise ignored (no strobe);
    - start -> if zero=0, en=1 and go to RUN; if zero=1 (all-zero entry), stay in LOAD;
    - stop -> ignored;
    - clear -> clear.
  - RUN:
    - en=1, busy=1;
    - digits and start ignored;
    - stop -> en=0, go to PAUSE;
    - zero=1 -> en=0, go to DONE.
  - PAUSE:
    - en=0, busy=1;
    - start -> en=1, go to RUN;
    - digits and stop ignored.
  - DONE:
    - en=0, digit_cnt=0;
    - any digit -> go to IDLE, then that same press is treated as the first digit of a new entry (load strobe emitted);
    - start and stop -> go to IDLE with no strobe.
- Same-cycle priority in RUN: clear > zero > stop.
- loadn is never low while en=1.
- tclrn and loadn are never low in the same cycle.

Optional Feature:
- Macro: TIMER_KEYPAD_BEEP_EN.
- When defined:
  - extra output port beep (1 bit, reset 0);
  - beep is asserted for 2^16 cycles on entry to DONE;
  - any press event or clear ends beep early.
- When undefined: no beep port and no beep counter logic. All other behaviour is identical.

Test Plan:
- Reset with keys=0 -> data=0, loadn=1, en=0, tclrn=1, digit_cnt=0, busy=0.
- DEBOUNCE_CYCLES=4: press digits 2,1,5,9 in IDLE, each held 10 cycles -> exactly 3 loadn strobes, with data=2,1,5 on the strobes; 9 ignored; digit_cnt=3.
- Key glitch held for 3 cycles, then key vector with bits 3 and 7 both held stable -> no strobe in either case.
- Load 1,0,0, then start with zero=0 -> en=1 on the cycle after the event, busy=1. Then stop -> en=0, state PAUSE. Then start -> en=1.
- In RUN, drive zero=1 in the same cycle as a stop event -> DONE (en=0); PAUSE is not entered.
- Clear during RUN -> one-cycle tclrn=0, en=0, digit_cnt=0, state IDLE. With TIMER_KEYPAD_BEEP_EN defined, reaching DONE sets beep=1 until the next key press.
